// File: rtl/pipe_monitor.sv
// rtl/pipe_monitor.sv - pipeline activity monitor with stall/retire counters,
// breakpoint/cycle-limit halt and a circular retire-address trace.
module pipe_monitor #(
  parameter  int NSTAGE      = 4,
  parameter  int CNT_W       = 32,
  parameter  int ADDR_W      = 32,
  parameter  int TRACE_DEPTH = 16,
  parameter  int MAX_CYCLES  = 0,
  localparam int IW          = $clog2(TRACE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic [NSTAGE-1:0]       v_i,
  input  logic [NSTAGE-1:0]       stall_i,
  input  logic                    retire_i,
  input  logic [ADDR_W-1:0]       retire_addr_i,
  input  logic                    brk_en_i,
  input  logic [ADDR_W-1:0]       brk_addr_i,
  input  logic [IW-1:0]           tr_idx_i,
  output logic [ADDR_W-1:0]       tr_addr_o,
  output logic [IW:0]             tr_count_o,
  output logic [CNT_W-1:0]        cycle_o,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic [NSTAGE*CNT_W-1:0] stall_cnt_o,
  output logic [1:0]              state_o,
  output logic                    halt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT =
    (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
  localparam logic [IW:0] TR_FULL = (IW+1)'(TRACE_DEPTH);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cycle_cnt, retire_cnt;
  logic [CNT_W-1:0]  stall_cnt [NSTAGE];
  logic [ADDR_W-1:0] trace_mem [TRACE_DEPTH];
  logic [IW-1:0]     wr_ptr;
  logic [IW:0]       tr_count;
  logic              running, brk_hit, lim_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign running = (state == RUN);
  assign brk_hit = retire_i && brk_en_i && (retire_addr_i == brk_addr_i);
  assign lim_hit = (MAX_CYCLES != 0) && (cycle_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = RUN;
      RUN:     if (brk_hit || lim_hit) state_n = HALT;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
    // clear keeps a running monitor running and sends everything else home
    if (clear_i) state_n = (state == RUN) ? RUN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      wr_ptr     <= '0;
      tr_count   <= '0;
      for (int k = 0; k < NSTAGE; k++) stall_cnt[k] <= '0;
    end else if (running) begin
      cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
      retire_cnt <= sat_inc(retire_cnt, retire_i);
      for (int k = 0; k < NSTAGE; k++)
        stall_cnt[k] <= sat_inc(stall_cnt[k], v_i[k] & stall_i[k]);
      if (retire_i) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (tr_count != TR_FULL) tr_count <= tr_count + 1'b1;
      end
    end
  end

  // Storage is not reset; entries past tr_count are never exposed.
  always_ff @(posedge clk) begin
    if (!rst && !clear_i && running && retire_i) trace_mem[wr_ptr] <= retire_addr_i;
  end

  logic [IW-1:0] oldest, rd_ptr;
  assign oldest = wr_ptr - tr_count[IW-1:0];
  assign rd_ptr = oldest + tr_idx_i;

  always_comb begin
    tr_addr_o = '0;
    if ((IW+1)'(tr_idx_i) < tr_count) tr_addr_o = trace_mem[rd_ptr];
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stall_out
    assign stall_cnt_o[g*CNT_W +: CNT_W] = stall_cnt[g];
  end

  assign tr_count_o   = tr_count;
  assign cycle_o      = cycle_cnt;
  assign retire_cnt_o = retire_cnt;
  assign state_o      = state;
  assign halt_o       = (state == HALT);

endmodule

// File: tb/tb_pipe_monitor.sv
// tb/tb_pipe_monitor.sv - scoreboard bench for pipe_monitor: a default instance,
// a MAX_CYCLES=8 instance and a CNT_W=4 instance share one stimulus stream.
module tb_pipe_monitor;

  logic        clk = 1'b0;
  logic        rst, start_i, clear_i, retire_i, brk_en_i;
  logic [3:0]  v_i, stall_i, tr_idx_i;
  logic [31:0] retire_addr_i, brk_addr_i;

  logic [31:0]  a_tr_addr, a_cycle, a_retire;
  logic [4:0]   a_tr_count;
  logic [127:0] a_stall;
  logic [1:0]   a_state;
  logic         a_halt;

  logic [31:0]  b_tr_addr, b_cycle, b_retire;
  logic [4:0]   b_tr_count;
  logic [127:0] b_stall;
  logic [1:0]   b_state;
  logic         b_halt;

  logic [31:0]  c_tr_addr;
  logic [3:0]   c_cycle, c_retire;
  logic [4:0]   c_tr_count;
  logic [15:0]  c_stall;
  logic [1:0]   c_state;
  logic         c_halt;

  always #5 clk = ~clk;

  pipe_monitor u_a (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .v_i(v_i),
    .stall_i(stall_i), .retire_i(retire_i), .retire_addr_i(retire_addr_i),
    .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i), .tr_idx_i(tr_idx_i),
    .tr_addr_o(a_tr_addr), .tr_count_o(a_tr_count), .cycle_o(a_cycle),
    .retire_cnt_o(a_retire), .stall_cnt_o(a_stall), .state_o(a_state), .halt_o(a_halt));

  pipe_monitor #(.MAX_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .v_i(v_i),
    .stall_i(stall_i), .retire_i(retire_i), .retire_addr_i(retire_addr_i),
    .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i), .tr_idx_i(tr_idx_i),
    .tr_addr_o(b_tr_addr), .tr_count_o(b_tr_count), .cycle_o(b_cycle),
    .retire_cnt_o(b_retire), .stall_cnt_o(b_stall), .state_o(b_state), .halt_o(b_halt));

  pipe_monitor #(.CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .v_i(v_i),
    .stall_i(stall_i), .retire_i(retire_i), .retire_addr_i(retire_addr_i),
    .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i), .tr_idx_i(tr_idx_i),
    .tr_addr_o(c_tr_addr), .tr_count_o(c_tr_count), .cycle_o(c_cycle),
    .retire_cnt_o(c_retire), .stall_cnt_o(c_stall), .state_o(c_state), .halt_o(c_halt));

  typedef enum int {
    A_STATE, A_HALT, A_CYCLE, A_RETIRE, A_TRCNT, A_TRADDR,
    A_STALL0, A_STALL1, A_STALL2, A_STALL3,
    B_STATE, B_HALT, B_CYCLE, B_RETIRE, B_TRCNT, B_TRADDR,
    C_CYCLE, C_STATE
  } sel_t;

  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] actual(input sel_t s);
    case (s)
      A_STATE:  return 32'(a_state);
      A_HALT:   return 32'(a_halt);
      A_CYCLE:  return a_cycle;
      A_RETIRE: return a_retire;
      A_TRCNT:  return 32'(a_tr_count);
      A_TRADDR: return a_tr_addr;
      A_STALL0: return a_stall[31:0];
      A_STALL1: return a_stall[63:32];
      A_STALL2: return a_stall[95:64];
      A_STALL3: return a_stall[127:96];
      B_STATE:  return 32'(b_state);
      B_HALT:   return 32'(b_halt);
      B_CYCLE:  return b_cycle;
      B_RETIRE: return b_retire;
      B_TRCNT:  return 32'(b_tr_count);
      B_TRADDR: return b_tr_addr;
      C_CYCLE:  return 32'(c_cycle);
      C_STATE:  return 32'(c_state);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; drain whatever is queued.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      act = actual(c.sel);
      n_checks++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
    end
  end

  task automatic expect_val(input string name, input sel_t sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic drain();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; retire_i = 1'b0; brk_en_i = 1'b0;
    v_i = '0; stall_i = '0; tr_idx_i = '0; retire_addr_i = '0; brk_addr_i = '0;
    step(2);
    rst = 1'b0;
    expect_val("rst_state", A_STATE, 32'd0);
    expect_val("rst_halt", A_HALT, 32'd0);
    expect_val("rst_cycle", A_CYCLE, 32'd0);
    expect_val("rst_trcount", A_TRCNT, 32'd0);
    expect_val("rst_traddr", A_TRADDR, 32'd0);
    drain();

    // 10 RUN cycles, stage 1 stalls for the first 3
    start_i = 1'b1; step(1); start_i = 1'b0;
    v_i = 4'b1111; stall_i = 4'b0010; step(3);
    stall_i = 4'b0000; step(7);
    expect_val("run10_cycle", A_CYCLE, 32'd10);
    expect_val("run10_state", A_STATE, 32'd1);
    expect_val("run10_stall0", A_STALL0, 32'd0);
    expect_val("run10_stall1", A_STALL1, 32'd3);
    expect_val("run10_stall2", A_STALL2, 32'd0);
    expect_val("run10_stall3", A_STALL3, 32'd0);
    expect_val("lim_cycle", B_CYCLE, 32'd8);
    expect_val("lim_state", B_STATE, 32'd2);
    expect_val("lim_halt", B_HALT, 32'd1);
    expect_val("narrow_cycle10", C_CYCLE, 32'd10);
    drain();

    // HALT ignores start; narrow counter saturates instead of wrapping
    start_i = 1'b1; stall_i = 4'b1111; step(10); start_i = 1'b0; stall_i = '0;
    expect_val("lim_frozen_cycle", B_CYCLE, 32'd8);
    expect_val("lim_frozen_state", B_STATE, 32'd2);
    expect_val("narrow_sat", C_CYCLE, 32'hF);
    expect_val("narrow_state", C_STATE, 32'd1);
    drain();

    // clear: RUN stays RUN, HALT goes to IDLE, counters zeroed
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    expect_val("clr_run_state", A_STATE, 32'd1);
    expect_val("clr_run_cycle", A_CYCLE, 32'd0);
    expect_val("clr_run_stall1", A_STALL1, 32'd0);
    expect_val("clr_halt_state", B_STATE, 32'd0);
    expect_val("clr_halt_cycle", B_CYCLE, 32'd0);
    drain();

    // breakpoint at 0x10 while retiring 0,4,8,C,10
    brk_en_i = 1'b1; brk_addr_i = 32'h10; retire_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire_addr_i = 32'(4 * i);
      step(1);
    end
    retire_i = 1'b0;
    tr_idx_i = 4'd4;
    expect_val("brk_retire", A_RETIRE, 32'd5);
    expect_val("brk_halt", A_HALT, 32'd1);
    expect_val("brk_cycle", A_CYCLE, 32'd5);
    expect_val("brk_trcount", A_TRCNT, 32'd5);
    expect_val("brk_idx4", A_TRADDR, 32'h10);
    drain();
    tr_idx_i = 4'd1; expect_val("brk_idx1", A_TRADDR, 32'h4); drain();
    tr_idx_i = 4'd5; expect_val("brk_idx5_empty", A_TRADDR, 32'h0); drain();

    // inputs while halted must not disturb anything
    retire_i = 1'b1; retire_addr_i = 32'h20; v_i = 4'hF; stall_i = 4'hF; step(3);
    retire_i = 1'b0; stall_i = '0;
    expect_val("halt_retire", A_RETIRE, 32'd5);
    expect_val("halt_trcount", A_TRCNT, 32'd5);
    expect_val("halt_cycle", A_CYCLE, 32'd5);
    expect_val("halt_stall0", A_STALL0, 32'd0);
    drain();

    // 20 retires of 4*i: trace wraps and keeps the newest 16
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    expect_val("clr_idle", A_STATE, 32'd0);
    drain();
    brk_en_i = 1'b0;
    start_i = 1'b1; step(1); start_i = 1'b0;
    retire_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      retire_addr_i = 32'(4 * i);
      step(1);
    end
    retire_i = 1'b0;
    tr_idx_i = 4'd0;
    expect_val("wrap_trcount", A_TRCNT, 32'd16);
    expect_val("wrap_retire", A_RETIRE, 32'd20);
    expect_val("wrap_cycle", A_CYCLE, 32'd20);
    expect_val("wrap_idx0", A_TRADDR, 32'h10);
    expect_val("lim_trace_count", B_TRCNT, 32'd8);
    expect_val("lim_trace_retire", B_RETIRE, 32'd8);
    drain();
    tr_idx_i = 4'd15; expect_val("wrap_idx15", A_TRADDR, 32'h4C); drain();
    tr_idx_i = 4'd7;
    expect_val("wrap_idx7", A_TRADDR, 32'h2C);
    expect_val("lim_idx7", B_TRADDR, 32'h1C);
    drain();

    // reset mid-RUN beats start/clear in the same cycle
    start_i = 1'b1; clear_i = 1'b1; rst = 1'b1; step(1);
    rst = 1'b0; start_i = 1'b0; clear_i = 1'b0; tr_idx_i = 4'd0;
    expect_val("rst_run_state", A_STATE, 32'd0);
    expect_val("rst_run_cycle", A_CYCLE, 32'd0);
    expect_val("rst_run_retire", A_RETIRE, 32'd0);
    expect_val("rst_run_trcount", A_TRCNT, 32'd0);
    expect_val("rst_run_traddr", A_TRADDR, 32'd0);
    expect_val("rst_run_halt", A_HALT, 32'd0);
    expect_val("rst_run_stall1", A_STALL1, 32'd0);
    drain();

    // breakpoint and cycle limit on the same cycle: one clean HALT
    brk_en_i = 1'b1; brk_addr_i = 32'h80;
    start_i = 1'b1; step(1); start_i = 1'b0;
    step(7);
    retire_i = 1'b1; retire_addr_i = 32'h80; step(1); retire_i = 1'b0;
    expect_val("both_state", B_STATE, 32'd2);
    expect_val("both_cycle", B_CYCLE, 32'd8);
    expect_val("both_retire", B_RETIRE, 32'd1);
    expect_val("both_trcount", B_TRCNT, 32'd1);
    expect_val("both_a_state", A_STATE, 32'd2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_monitor.md
PIPE_MONITOR -- requirements
Module: pipe_monitor

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, number of pipeline stages observed.
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-003 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-004 SHALL have parameter TRACE_DEPTH, default 16, retire-trace entries (power of 2, >=2); IW = log2(TRACE_DEPTH).
REQ-005 SHALL have parameter MAX_CYCLES, default 0, RUN-cycle limit (0 = unlimited).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  begin monitoring.
REQ-009 clear_i  in  1  clear counters/trace, leave HALT.
REQ-010 v_i  in  NSTAGE  per-stage valid, bit k = stage k.
REQ-011 stall_i  in  NSTAGE  per-stage stall, bit k = stage k.
REQ-012 retire_i  in  1  instruction writes back this cycle.
REQ-013 retire_addr_i  in  ADDR_W  original address of retiring instruction.
REQ-014 brk_en_i  in  1  breakpoint enable.
REQ-015 brk_addr_i  in  ADDR_W  breakpoint address.
REQ-016 tr_idx_i  in  IW  trace read index, 0 = oldest entry.
REQ-017 tr_addr_o  out  ADDR_W  trace entry at tr_idx_i.
REQ-018 tr_count_o  out  IW+1  valid trace entries.
REQ-019 cycle_o  out  CNT_W  RUN cycles counted.
REQ-020 retire_cnt_o  out  CNT_W  retirements counted.
REQ-021 stall_cnt_o  out  NSTAGE*CNT_W  stage k stall count in bits [k*CNT_W +: CNT_W].
REQ-022 state_o  out  2  IDLE=00, RUN=01, HALT=10.
REQ-023 halt_o  out  1  high iff state is HALT.

Function
REQ-024 FSM SHALL go IDLE->RUN on start_i; start_i SHALL be ignored in RUN and HALT.
REQ-025 RUN->HALT SHALL occur on breakpoint hit: retire_i & brk_en_i & retire_addr_i==brk_addr_i.
REQ-026 RUN->HALT SHALL occur when MAX_CYCLES!=0 and cycle_o==MAX_CYCLES-1 in RUN, so cycle_o reads MAX_CYCLES in HALT.
REQ-027 Simultaneous breakpoint and cycle limit SHALL give a single HALT transition.
REQ-028 HALT->IDLE SHALL occur only on clear_i.
REQ-029 clear_i in any state SHALL zero all counters, trace pointer and tr_count_o next cycle, priority over same-cycle increments; in RUN state SHALL remain RUN; in IDLE remain IDLE.
REQ-030 In RUN only: cycle_o +1 per cycle; retire_cnt_o +1 when retire_i; stall counter k +1 when v_i[k]&stall_i[k].
REQ-031 All counters SHALL saturate at all-ones, no wrap.
REQ-032 In RUN, retire_i SHALL write retire_addr_i at write pointer; pointer wraps TRACE_DEPTH-1->0, overwriting oldest.
REQ-033 tr_count_o SHALL increment per traced retire and saturate at TRACE_DEPTH.
REQ-034 tr_addr_o SHALL be combinational from tr_idx_i relative to oldest valid entry; tr_idx_i>=tr_count_o SHALL return 0.
REQ-035 Breakpoint-hit retirement SHALL be counted and traced in its own cycle; HALT visible next cycle.
REQ-036 Inputs in IDLE/HALT SHALL not change counters or trace.

Reset
REQ-037 rst SHALL set state IDLE, all counters 0, tr_count_o 0, write pointer 0, halt_o 0, tr_addr_o 0.
REQ-038 rst SHALL override start_i and clear_i in the same cycle, including mid-RUN.

Verification
REQ-039 start_i, 10 RUN cycles, stall_i=4'b0010 v_i=4'b1111 for 3 -> cycle_o=10, stage1 stall=3, others 0.
REQ-040 brk_addr_i=0x0000_0010, retire 0x0,0x4,...,0x10 -> retire_cnt_o=5, halt_o=1 next cycle, tr_addr_o(idx4)=0x10.
REQ-041 TRACE_DEPTH=16, 20 retires of 4*i -> tr_count_o=16, idx0=0x10, idx15=0x4C.
REQ-042 MAX_CYCLES=8 -> HALT after 8 RUN cycles, cycle_o=8; further inputs no change; clear_i -> IDLE, all zero.
REQ-043 CNT_W=4, 20 RUN cycles -> cycle_o=4'hF, no wrap.
REQ-044 rst asserted mid-RUN with counters nonzero -> next cycle state_o=00, all outputs 0.
